// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences each instruction through the fetch/decode/execute/
// memory/writeback states and drives the ALU control code, datapath mux selects and write enables.
module mips_multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] Op,
  input  logic [OPW-1:0] Funct,
  input  logic           Zero,
  output logic [2:0]     ALUControl,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           illegal,
  output logic [STW-1:0] state
);

  typedef enum logic [STW-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg, state_next;
  logic       illegal_reg, illegal_next;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic [2:0] alu_ctrl;
  logic       src_a, iord, reg_dst, mem_to_reg;
  logic [1:0] src_b, pc_src;
  logic       pc_write, branch, ir_write, mem_write, reg_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = S_FETCH;
    illegal_next = 1'b0;
    alu_ctrl     = ALU_ADD;
    src_a        = 1'b0;
    src_b        = 2'b00;
    pc_src       = 2'b00;
    pc_write     = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    mem_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b01;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH can use it from ALUOut.
        src_b = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a      = 1'b1;
        src_b      = 2'b10;
        state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTE: begin
        src_a    = 1'b1;
        alu_ctrl = funct_alu;
        if (funct_ok) begin
          state_next = S_ALUWB;
        end else begin
          state_next   = S_FETCH;
          illegal_next = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        src_a      = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        src_a      = 1'b1;
        src_b      = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Enables are gated by reset_n so nothing writes while reset is held, even though FETCH is current.
  assign PCEn       = reset_n & (pc_write | (branch & Zero));
  assign IRWrite    = reset_n & ir_write;
  assign MemWrite   = reset_n & mem_write;
  assign RegWrite   = reset_n & reg_write;
  assign ALUControl = reset_n ? alu_ctrl : ALU_ADD;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign PCSrc      = pc_src;
  assign IorD       = iord;
  assign RegDst     = reg_dst;
  assign MemtoReg   = mem_to_reg;
  assign illegal    = illegal_reg;
  assign state      = state_reg;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit: the producer side of the ALU control interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Each cycle it drives the 3-bit ALU operation code, operand selects, mux selects and write enables.
- It consumes the ALU Zero flag to resolve beq, and sits between the instruction register and the datapath.

Parameters:
- OPW, 6, opcode and funct field width.
- STW, 4, state register width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- Op  in  OPW  instruction[31:26] from the instruction register
- Funct  in  OPW  instruction[5:0]
- Zero  in  1  ALU zero flag
- ALUControl  out  3  ALU operation code
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable
- IorD  out  1  memory address select, 1 = ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register load
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = memory data
- RegWrite  out  1  register file write
- illegal  out  1  one-cycle pulse on unsupported opcode or funct
- state  out  STW  current state, for debug

Behaviour:
- Reset: asynchronous on reset_n low. State goes to FETCH and illegal goes to 0.
- While reset_n is low, PCEn, IRWrite, MemWrite and RegWrite are forced to 0 combinationally, and ALUControl = 010. The first rising edge after release executes FETCH.
- Moore outputs are decoded from the state register. PCEn = PCWrite | (Branch & Zero), and is combinational on Zero.
- Unlisted outputs are 0 in each state. ALUControl is 010 unless stated.
- States:
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11 (branch target precompute).
  - DECODE next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with illegal=1 registered on that edge (visible for the following cycle only)
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct. Next: ALUWB.
  - EXECUTE funct map:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> ALUControl=010, and the next state is FETCH instead of ALUWB, with illegal pulsed. No register write occurs.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- ALUControl only ever takes the values 010, 110, 000, 001, 111. An X or any other code is a bug.
- Unreachable state encodings return to FETCH on the next edge, with all enables 0 while in them.
- Latency in cycles, counted from entering FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Reset asserted mid-instruction aborts immediately. No write enable is asserted after reset_n falls.

Test Plan:
- Reset: hold reset_n=0 with clk running -> state=FETCH, PCEn=IRWrite=MemWrite=RegWrite=0, ALUControl=010, illegal=0. Release -> FETCH outputs PCEn=1, IRWrite=1, ALUSrcB=01.
- lw: Op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH. ALUSrcB=10 in MEMADR, RegWrite=1 only in MEMWB. sw: Op=101011 -> MemWrite=1 for exactly one cycle (MEMWR), 4-cycle sequence.
- R-type: Op=0 with Funct=100010 -> ALUControl=110 in EXECUTE, then RegDst=1, RegWrite=1. Repeat for 100000/100100/100101/101010 -> 010/000/001/111.
- beq: Op=000100 with Zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUControl=110. Same with Zero=0 -> PCEn=0. Toggle Zero mid-cycle -> PCEn follows combinationally.
- Illegal: Op=111111 -> DECODE goes to FETCH, illegal=1 for one cycle, no write enables. Op=0 with Funct=000111 -> EXECUTE goes to FETCH, illegal pulse, RegWrite never 1.
- Reset mid-op: drop reset_n asynchronously during MEMWB -> RegWrite falls to 0 immediately, state=FETCH.
